// File: rtl/mac_drain_pkg.sv
// Shared types and helpers for the MAC result drain buffer.
package mac_drain_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } drain_op_t;

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        if (ptr == 32'(depth - 1)) begin
            return '0;
        end
        return ptr + 32'd1;
    endfunction

endpackage

// File: rtl/drain_ptr_ctr.sv
// Wrapping circular-buffer pointer, advanced on the falling clock edge when inc is high.
module drain_ptr_ctr
    import mac_drain_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_n,
    input  logic                     rst_n,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = PTR_W'(ptr_inc(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mac_result_drain.sv
// Circular FWFT buffer draining MAC results to a valid/ready consumer on the falling edge.
// Optional sticky overflow flag (clr_ovf/ovf ports) enabled by MAC_DRAIN_OVF_STICKY_EN.
module mac_result_drain
    import mac_drain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_n,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] datain,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic [CNT_W-1:0] count
`ifdef MAC_DRAIN_OVF_STICKY_EN
    ,
    input  logic             clr_ovf,
    output logic             ovf
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             wr_en;
    drain_op_t        op;

    // Status comes only from the registered count, never from ld/out_ready.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = ld & (~full | pop);
    assign count     = count_q;
    assign dataout   = out_valid ? mem_q[rd_ptr] : '0;

    always_comb begin
        op      = OP_IDLE;
        count_d = count_q;
        if (wr_en && pop) begin
            op = OP_BOTH;
        end else if (wr_en) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        case (op)
            OP_PUSH: count_d = count_q + CNT_W'(1);
            OP_POP:  count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; count gates visibility.
    always_ff @(negedge clk_n) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= datain;
        end
    end

    drain_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_n (clk_n),
        .rst_n (rst_n),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    drain_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_n (clk_n),
        .rst_n (rst_n),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

`ifdef MAC_DRAIN_OVF_STICKY_EN
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (ld && !wr_en) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed plus randomized bench for mac_result_drain against a queue-based reference model.
module tb_mac_result_drain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_n = 1'b1;
    logic             rst_n;
    logic             ld;
    logic [WIDTH-1:0] datain;
    logic             full;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataout;
    logic [CNT_W-1:0] count;
    logic             clr_ovf;
`ifdef MAC_DRAIN_OVF_STICKY_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;

    always #5 clk_n = ~clk_n;

    mac_result_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_n     (clk_n),
        .rst_n     (rst_n),
        .ld        (ld),
        .datain    (datain),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .count     (count)
`ifdef MAC_DRAIN_OVF_STICKY_EN
        ,
        .clr_ovf   (clr_ovf),
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".dout"}, 32'(dataout), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
`ifdef MAC_DRAIN_OVF_STICKY_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
    endtask

    // One falling edge with the given inputs; model follows the behavioural rules directly.
    task automatic step(input bit l, input logic [WIDTH-1:0] d, input bit r, input bit c,
                        input string tag);
        bit m_pop;
        bit m_wr;
        ld = l; datain = d; out_ready = r; clr_ovf = c;
        m_pop = (mq.size() != 0) && r;
        m_wr  = l && ((mq.size() != DEPTH) || m_pop);
        @(negedge clk_n);
        #1;
        if (m_pop) void'(mq.pop_front());
        if (m_wr) mq.push_back(d);
        if (l && !m_wr) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        rst_n = 1'b0; ld = 1'b0; datain = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        chk_all("reset0");
        #2 rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle clears everything at once.
        step(1, 8'hA1, 0, 0, "pre_rst_a");
        step(1, 8'hA2, 0, 0, "pre_rst_b");
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); m_ovf = 1'b0;
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.dout", 32'(dataout), 32'd0);
        #1 rst_n = 1'b1;

        // Fill without draining.
        step(1, 8'h11, 0, 0, "fill1");
        step(1, 8'h22, 0, 0, "fill2");
        step(1, 8'h33, 0, 0, "fill3");
        step(1, 8'h44, 0, 0, "fill4");
        chk("fill.full_const", 32'(full), 32'd1);
        chk("fill.count_const", 32'(count), 32'd4);

        // Dropped write at full.
        step(1, 8'hAA, 0, 0, "ovf_drop");
        chk("ovf_drop.dout_const", 32'(dataout), 32'h11);
        step(0, 8'h00, 0, 0, "ovf_hold");
        step(0, 8'h00, 0, 1, "ovf_clr");

        // Simultaneous push and pop at full.
        step(1, 8'h55, 1, 0, "both_full");
        chk("both_full.count_const", 32'(count), 32'd4);
        chk("both_full.dout_const", 32'(dataout), 32'h22);

        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "drain");
        chk("drain.empty_const", 32'(out_valid), 32'd0);
        step(0, 8'h00, 1, 0, "empty_ready");

        // Push/pop pairs walk both pointers around the ring.
        for (int i = 0; i < 10; i++) step(1, 8'(i), 1, 0, "wrap");
        chk("wrap.last_const", 32'(dataout), 32'd9);
        step(0, 8'h00, 1, 0, "wrap_drain");

        // Stall: output must hold while consumer is not ready.
        step(1, 8'h5A, 0, 0, "stall_fill1");
        step(1, 8'hC3, 0, 0, "stall_fill2");
        held = dataout;
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 0, "stall");
            chk("stall.dout_held", 32'(dataout), 32'(held));
        end

        // Random traffic, including overflow set/clear collisions.
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 2) == 0),
                 bit'($urandom_range(0, 7) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
